icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
Direct-mapped, read-only instruction cache between the instruction fetch unit's instruction bus and the memory fabric. It serves hits from on-chip arrays with a fixed one-cycle read latency. Misses are refilled line-by-line over a word-wide memory-side bus. Both sides use the core's Avalon-style read handshake: fire = read & ~waitrequest, and readdata is valid exactly one cycle after the fire.

Parameters:
NUM_LINES, 64, number of cache lines (power of 2, >=2)
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)
ADDR_WIDTH, 32, byte address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cpu_read  input  1  fetch read request
cpu_address  input  ADDR_WIDTH  fetch byte address, word aligned
cpu_readdata  output  32  instruction word, valid the cycle after a cpu fire
cpu_waitrequest  output  1  request not accepted this cycle
mem_read  output  1  refill read request
mem_address  output  ADDR_WIDTH  refill word address
mem_readdata  input  32  refill data, valid the cycle after a mem fire
mem_waitrequest  input  1  memory stall
invalidate  input  1  single-cycle pulse; invalidate all lines (fence.i)

Behaviour:
- Reset: rst is synchronous, active-high; clock clk.
- Reset values: all valid bits 0; state IDLE; mem_read 0; cpu_waitrequest 1 while rst is high; cpu_readdata 0.
- Address split:
  - bits[1:0] ignored;
  - offset = next log2(LINE_WORDS) bits;
  - index = next log2(NUM_LINES) bits;
  - tag = remaining upper bits.
- Storage:
  - tag and valid bits in flops, looked up combinationally;
  - data array with registered read.
- hit = valid[index] & tag_array[index]==tag & ~inv_pending.
- IDLE:
  - cpu_waitrequest = ~(cpu_read & hit).
  - On a hit fire, the data word is registered to cpu_readdata for the next cycle.
  - On cpu_read & ~hit: latch the line base {tag,index,0}, zero the issue and receive counters, go REFILL. cpu_waitrequest stays 1.
- REFILL:
  - mem_read=1 while issued < LINE_WORDS; mem_address = line_base + 4*issued.
  - issued increments on each mem fire; reads may be back-to-back.
  - Each cycle after a fire, mem_readdata is written to data[index][received] and received increments.
  - When the last word is written: valid[index] is set, tag is written, and the state returns to IDLE. The request is then served as a hit.
  - cpu_waitrequest=1 throughout REFILL.
- Zero-wait memory miss timing: request at cycle 0; mem fires at cycles 1-4; data arrives cycles 2-5; cpu fire at cycle 6; cpu_readdata valid at cycle 7.
- A cpu_read drop or address change during REFILL does not abort the refill. The line always completes, since the fetch unit holds its address while waitrequest is high.
- Invalidate:
  - In IDLE: clears all valid bits at the next edge; the same-cycle lookup is forced to miss.
  - During REFILL: sets inv_pending; the refill completes; the line's valid is then not set, and all valid bits clear on the return to IDLE. The request then misses again.
- Reset mid-refill: abandons the refill immediately. Late mem_readdata is ignored; no array write occurs after rst.
- The counters are log2(LINE_WORDS)+1 bits wide; no wrap is possible within a refill.

Optional Feature:
ICACHE_STATS_EN
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments on every cpu fire not directly following a refill.
  - miss_count increments on every IDLE->REFILL transition.
  - Both saturate at 0xFFFF_FFFF.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss, zero-wait memory, cpu_read 0x0000_1010:
  - mem reads 0x1010, 0x1014, 0x1018, 0x101C at cycles 1-4;
  - cpu fire at cycle 6;
  - cpu_readdata = word at 0x1010 at cycle 7.
- After that refill, reads of 0x1014, 0x1018 and 0x101C back-to-back: waitrequest 0 every cycle, with one-cycle data latency. (miss_count=1, hit_count=3 with ICACHE_STATS_EN.)
- Conflict: read 0x2010 (same index 1, tag 8) evicts the line; a subsequent read of 0x1010 misses again and refetches.
- Memory waitrequest high 3 cycles on each word: mem_address is held stable while stalled, the words land in the correct offsets, and the final readdata is correct.
- Invalidate pulse during refill of line 1: the refill completes, then 0x1010 misses again; an invalidate in IDLE followed by a read of a resident line gives a miss.
- rst asserted at refill cycle 3: mem_read=0 the next cycle, all lines are invalid, and the first read after reset misses.

Source files
------------

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side Avalon-style read buses of the instruction cache.
// The slave modport is the cache's view; master is the fetch unit / fabric view.
interface icache_dm_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_read;
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [31:0]           cpu_readdata;
    logic                  cpu_waitrequest;
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_readdata;
    logic                  mem_waitrequest;
    logic                  invalidate;

    modport slave (
        input  cpu_read, cpu_address, mem_readdata, mem_waitrequest, invalidate,
        output cpu_readdata, cpu_waitrequest, mem_read, mem_address
    );

    modport master (
        output cpu_read, cpu_address, mem_readdata, mem_waitrequest, invalidate,
        input  cpu_readdata, cpu_waitrequest, mem_read, mem_address
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with line refill over a word-wide bus.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache_dm #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    icache_dm_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam int CNT_W = OFF_W + 1;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                   state_q, state_d;
    logic [NUM_LINES-1:0]     valid_q, valid_d;
    logic                     inv_pending_q, inv_pending_d;
    logic [TAG_W+IDX_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]         issued_q, issued_d;
    logic [CNT_W-1:0]         recv_q, recv_d;
    logic                     rvalid_q, rvalid_d;
    logic [31:0]              readdata_q, readdata_d;

    logic [TAG_W-1:0]         tag_mem  [NUM_LINES];
    logic [31:0]              data_mem [NUM_LINES*LINE_WORDS];

    logic [TAG_W-1:0]         cpu_tag;
    logic [IDX_W-1:0]         cpu_idx;
    logic [OFF_W-1:0]         cpu_off;
    logic [IDX_W-1:0]         base_idx;
    logic [TAG_W-1:0]         base_tag;
    logic                     hit, mem_read_c, mem_fire, cpu_wait_c;
    logic                     data_we, tag_we;
    logic                     unused_addr_bits;

    assign cpu_off  = bus.cpu_address[2 +: OFF_W];
    assign cpu_idx  = bus.cpu_address[2+OFF_W +: IDX_W];
    assign cpu_tag  = bus.cpu_address[ADDR_WIDTH-1 -: TAG_W];
    assign base_idx = base_q[IDX_W-1:0];
    assign base_tag = base_q[TAG_W+IDX_W-1:IDX_W];
    assign unused_addr_bits = ^bus.cpu_address[1:0];

    // An invalidate arriving this cycle forces the lookup to miss.
    assign hit = valid_q[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag)
               & ~inv_pending_q & ~bus.invalidate;

    assign mem_read_c = ~rst & (state_q == REFILL) & ~issued_q[OFF_W];
    assign mem_fire   = mem_read_c & ~bus.mem_waitrequest;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        inv_pending_d = inv_pending_q;
        base_d        = base_q;
        issued_d      = issued_q;
        recv_d        = recv_q;
        rvalid_d      = mem_fire;
        readdata_d    = readdata_q;
        cpu_wait_c    = 1'b1;
        data_we       = 1'b0;
        tag_we        = 1'b0;
        unique case (state_q)
            IDLE: begin
                cpu_wait_c = ~(bus.cpu_read & hit);
                if (bus.cpu_read & hit)
                    readdata_d = data_mem[{cpu_idx, cpu_off}];
                if (bus.invalidate)
                    valid_d = '0;
                if (bus.cpu_read & ~hit) begin
                    base_d   = {cpu_tag, cpu_idx};
                    issued_d = '0;
                    recv_d   = '0;
                    state_d  = REFILL;
                end
            end
            REFILL: begin
                if (mem_fire)
                    issued_d = issued_q + CNT_W'(1);
                if (bus.invalidate)
                    inv_pending_d = 1'b1;
                if (rvalid_q) begin
                    data_we = 1'b1;
                    recv_d  = recv_q + CNT_W'(1);
                    if (recv_q == CNT_W'(LINE_WORDS - 1)) begin
                        // Line is complete; a pending invalidate wins over marking it valid.
                        tag_we        = 1'b1;
                        inv_pending_d = 1'b0;
                        state_d       = IDLE;
                        if (inv_pending_q | bus.invalidate)
                            valid_d = '0;
                        else
                            valid_d[base_idx] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            cpu_wait_c = 1'b1;
            data_we    = 1'b0;
            tag_we     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            inv_pending_q <= 1'b0;
            base_q        <= '0;
            issued_q      <= '0;
            recv_q        <= '0;
            rvalid_q      <= 1'b0;
            readdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            inv_pending_q <= inv_pending_d;
            base_q        <= base_d;
            issued_q      <= issued_d;
            recv_q        <= recv_d;
            rvalid_q      <= rvalid_d;
            readdata_q    <= readdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we)
            data_mem[{base_idx, recv_q[OFF_W-1:0]}] <= bus.mem_readdata;
        if (tag_we)
            tag_mem[base_idx] <= base_tag;
    end

    assign bus.cpu_readdata    = readdata_q;
    assign bus.cpu_waitrequest = cpu_wait_c;
    assign bus.mem_read        = mem_read_c;
    assign bus.mem_address     = {base_q, issued_q[OFF_W-1:0], 2'b00};

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        just_filled_q, just_filled_d;

    // The fire that completes a missed request is not counted as a hit.
    always_comb begin
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        just_filled_d = (state_q == REFILL) & (state_d == IDLE);
        if (~cpu_wait_c & ~just_filled_q & ~&hit_count_q)
            hit_count_d = hit_count_q + 32'd1;
        if ((state_q == IDLE) & (state_d == REFILL) & ~&miss_count_q)
            miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q   <= '0;
            miss_count_q  <= '0;
            just_filled_q <= 1'b0;
        end else begin
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
            just_filled_q <= just_filled_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: miss timing, hits, conflicts, stalls, invalidate, reset.
module tb_icache_dm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_dm_if #(.ADDR_WIDTH(32)) bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_dm #(.NUM_LINES(64), .LINE_WORDS(4), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: word at address a is a ^ 32'hDEAD0000, one cycle after the fire.
    int          cyc = 0;
    int          base_cyc = 0;
    logic        stall_en = 1'b0;
    int          stall_cnt = 0;
    int          addr_changes = 0;
    logic        prev_stalled = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] fire_addr[$];
    int          fire_cyc[$];

    assign bus.mem_waitrequest = stall_en && (stall_cnt < 3);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_read && !bus.mem_waitrequest) begin
            bus.mem_readdata <= bus.mem_address ^ 32'hDEAD0000;
            fire_addr.push_back(bus.mem_address);
            fire_cyc.push_back(cyc - base_cyc);
            stall_cnt <= 0;
        end else begin
            bus.mem_readdata <= 32'hBAD0BAD0;
            if (bus.mem_read)
                stall_cnt <= stall_cnt + 1;
        end
        if (prev_stalled && bus.mem_read && bus.mem_address != prev_addr)
            addr_changes <= addr_changes + 1;
        prev_stalled <= bus.mem_read && bus.mem_waitrequest;
        prev_addr    <= bus.mem_address;
    end

    task automatic read_line(input logic [31:0] addr, input logic [31:0] exp_data,
                             input int exp_wait, input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.cpu_read    = 1'b1;
        bus.cpu_address = addr;
        base_cyc        = cyc;
        fire_addr.delete();
        fire_cyc.delete();
        @(negedge clk);
        while (bus.cpu_waitrequest && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_wait"}, n, exp_wait);
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
        @(negedge clk);
        check({tag, "_data"}, bus.cpu_readdata, exp_data);
    endtask

    task automatic check_fires(input logic [31:0] base, input int first_cyc,
                               input int spacing, input string tag);
        check({tag, "_nfires"}, fire_addr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_faddr"}, (k < fire_addr.size()) ? fire_addr[k] : 32'hFFFFFFFF,
                  base + 32'(4 * k));
            check({tag, "_fcyc"}, (k < fire_cyc.size()) ? fire_cyc[k] : -1,
                  first_cyc + spacing * k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.cpu_read    = 1'b1;
        bus.cpu_address = 32'h0000_1010;
        bus.invalidate  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wait", bus.cpu_waitrequest, 1'b1);
        check("rst_memread", bus.mem_read, 1'b0);
        check("rst_rdata", bus.cpu_readdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.cpu_read = 1'b0;

        // Cold miss, zero-wait memory
        read_line(32'h0000_1010, 32'hDEAD1010, 6, "cold");
        check_fires(32'h0000_1010, 1, 1, "cold");

        // Back-to-back hits on the freshly filled line
        @(posedge clk); #1;
        bus.cpu_read = 1'b1; bus.cpu_address = 32'h0000_1014;
        @(negedge clk);
        check("b2b_wait1", bus.cpu_waitrequest, 1'b0);
        @(posedge clk); #1;
        bus.cpu_address = 32'h0000_1018;
        @(negedge clk);
        check("b2b_wait2", bus.cpu_waitrequest, 1'b0);
        check("b2b_data1", bus.cpu_readdata, 32'hDEAD1014);
        @(posedge clk); #1;
        bus.cpu_address = 32'h0000_101C;
        @(negedge clk);
        check("b2b_wait3", bus.cpu_waitrequest, 1'b0);
        check("b2b_data2", bus.cpu_readdata, 32'hDEAD1018);
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
        @(negedge clk);
        check("b2b_data3", bus.cpu_readdata, 32'hDEAD101C);
`ifdef ICACHE_STATS_EN
        check("stats_miss", miss_count, 32'd1);
        check("stats_hit", hit_count, 32'd3);
`endif

        // Conflict on index 1
        read_line(32'h0000_2010, 32'hDEAD2010, 6, "conf_evict");
        read_line(32'h0000_1010, 32'hDEAD1010, 6, "conf_refetch");
        read_line(32'h0000_1014, 32'hDEAD1014, 0, "conf_hit");

        // Memory stalls 3 cycles per word: fires at 4, 8, 12, 16
        stall_en = 1'b1;
        read_line(32'h0000_302C, 32'hDEAD302C, 18, "stall");
        check_fires(32'h0000_3020, 4, 4, "stall");
        check("stall_addr_stable", addr_changes, 0);
        stall_en = 1'b0;
        read_line(32'h0000_3024, 32'hDEAD3024, 0, "stall_hit");

        // Invalidate in IDLE, then a resident line misses
        @(posedge clk); #1;
        bus.invalidate = 1'b1;
        @(posedge clk); #1;
        bus.invalidate = 1'b0;
        read_line(32'h0000_1010, 32'hDEAD1010, 6, "inv_idle");

        // Invalidate during refill: line completes unvalidated, request refills again
        fork
            read_line(32'h0000_2010, 32'hDEAD2010, 12, "inv_refill");
            begin
                repeat (3) @(posedge clk);
                #1 bus.invalidate = 1'b1;
                @(posedge clk);
                #1 bus.invalidate = 1'b0;
            end
        join
        read_line(32'h0000_3024, 32'hDEAD3024, 6, "inv_other_line");
        read_line(32'h0000_1010, 32'hDEAD1010, 6, "inv_line1");

        // Reset at refill cycle 3
        @(posedge clk); #1;
        bus.cpu_read = 1'b1; bus.cpu_address = 32'h0000_4040;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.cpu_read = 1'b0;
        @(negedge clk);
        check("rstmid_memread", bus.mem_read, 1'b0);
        check("rstmid_rdata", bus.cpu_readdata, 32'h0);
        read_line(32'h0000_1010, 32'hDEAD1010, 6, "rstmid_miss1");
        read_line(32'h0000_4040, 32'hDEAD4040, 6, "rstmid_miss2");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
